imem_loader: RTL



---
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader for the instruction memory.
// Frame: SYNC, LEN_LO, LEN_HI, 4*N data bytes (LSB first per word), CHK (sum mod 256).
// Optional feature macro: IMEM_LOADER_CPU_HOLD_EN. When it is defined,
// cpu_reset_req holds the processor for the whole load.
module imem_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic              m_debugaccess,
    output logic              m_clken,
    output logic              cpu_reset_req,
    output logic              busy,
    output logic              done,
    output logic              error
);
    // CHK_EV is the single evaluation cycle after the checksum byte arrives.
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_CHK_EV, S_ERR_DRAIN
    } state_t;

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic              started_q, started_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        chk_byte_q, chk_byte_d;
    logic [ADDR_W-1:0] m_address_q, m_address_d;
    logic [31:0]       m_writedata_q, m_writedata_d;
    logic              m_write_q, m_write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              xfer;
    logic              sync_hit;
    logic [16:0]       len_new;

    // started_q keeps s_ready low while reset is held and releases it after the first edge.
    assign s_ready  = started_q && (state_q != S_CHK_EV) && (state_q != S_ERR_DRAIN);
    assign xfer     = s_valid && s_ready;
    assign sync_hit = xfer && (state_q == S_IDLE) && (s_data == SYNC_BYTE);
    assign len_new  = {1'b0, s_data, len_q[7:0]};

    // Next-state, datapath and status update.
    always_comb begin
        state_d       = state_q;
        started_d     = 1'b1;
        len_d         = len_q;
        wcnt_d        = wcnt_q;
        bcnt_d        = bcnt_q;
        word_d        = word_q;
        sum_d         = sum_q;
        chk_byte_d    = chk_byte_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        m_write_d     = 1'b0;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        case (state_q)
            S_IDLE: begin
                if (sync_hit) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    wcnt_d      = '0;
                    bcnt_d      = '0;
                    sum_d       = '0;
                    m_address_d = '0;
                    state_d     = S_LEN0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = s_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d[15:8] = s_data;
                    if (len_new > DEPTH)    state_d = S_ERR_DRAIN;
                    else if (len_new == '0) state_d = S_CHK;
                    else                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d = {s_data, word_q[31:8]};
                    sum_d  = sum_q + s_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Word complete: strobe it out at the current word index.
                        m_write_d     = 1'b1;
                        m_writedata_d = {s_data, word_q[31:8]};
                        m_address_d   = wcnt_q[ADDR_W-1:0];
                        wcnt_d        = wcnt_q + 16'd1;
                        if (wcnt_q + 16'd1 == len_q) state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (xfer) begin
                    chk_byte_d = s_data;
                    state_d    = S_CHK_EV;
                end
            end
            S_CHK_EV: begin
                if (chk_byte_q == sum_q) done_d  = 1'b1;
                else                     error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR_DRAIN: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            started_q     <= 1'b0;
            len_q         <= '0;
            wcnt_q        <= '0;
            bcnt_q        <= '0;
            word_q        <= '0;
            sum_q         <= '0;
            chk_byte_q    <= '0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            m_write_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            started_q     <= started_d;
            len_q         <= len_d;
            wcnt_q        <= wcnt_d;
            bcnt_q        <= bcnt_d;
            word_q        <= word_d;
            sum_q         <= sum_d;
            chk_byte_q    <= chk_byte_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            m_write_q     <= m_write_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

`ifdef IMEM_LOADER_CPU_HOLD_EN
    logic hold_q, hold_d;

    // Hold set on sync; cleared one cycle after busy drops so the last write is covered.
    always_comb begin
        hold_d = hold_q;
        if (sync_hit)     hold_d = 1'b1;
        else if (!busy_q) hold_d = 1'b0;
    end

    // Hold request register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_q <= 1'b0;
        else       hold_q <= hold_d;
    end

    assign cpu_reset_req = hold_q;
`else
    assign cpu_reset_req = 1'b0;
`endif

    assign m_address     = m_address_q;
    assign m_writedata   = m_writedata_q;
    assign m_write       = m_write_q;
    assign m_chipselect  = m_write_q;
    assign m_debugaccess = m_write_q;
    assign m_byteenable  = {4{m_write_q}};
    assign m_clken       = 1'b1;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule
